// File: rtl/codec_unit_pkg.sv
// rtl/codec_unit_pkg.sv - shared state, status codes and helpers for the CODEC I2C arbiter
package codec_unit_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT_BUSY,
    ARB_WAIT_DONE,
    ARB_RESPOND
  } arb_state_t;

  localparam logic [1:0] ARB_STATUS_OK      = 2'b00;
  localparam logic [1:0] ARB_STATUS_NACK    = 2'b01;
  localparam logic [1:0] ARB_STATUS_TIMEOUT = 2'b10;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/codec_i2c_arbiter_picker.sv
// rtl/codec_i2c_arbiter_picker.sv - round-robin picker: first valid requester at or after rr_ptr
module rr_priority_picker #(
  parameter int NUM_REQ = 2,
  localparam int PTR_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               any_valid
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (!any_valid && valid[j]) begin
        any_valid = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/codec_i2c_arbiter.sv
// rtl/codec_i2c_arbiter.sv - round-robin arbiter sharing one CODEC I2C controller between requesters
module codec_i2c_arbiter
  import codec_unit_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 9,
  parameter int BUSY_START_CYC = 16,
  parameter int TIMEOUT_CYC    = 1_000_000
) (
  input  logic                      board_clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [1:0]                rsp_status,
  input  logic                      codec_init_done,
  output logic                      codec_rd_en,
  output logic                      codec_wr_en,
  output logic [ADDR_W-1:0]         codec_reg_addr,
  output logic [DATA_W-1:0]         codec_data_in,
  input  logic [DATA_W-1:0]         codec_data_out,
  input  logic                      codec_data_out_valid,
  input  logic                      controller_busy,
  input  logic                      missed_ack
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_START_CYC - 1);
  localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [PTR_W-1:0]   rr_ptr_q, grant_idx_q;
  logic               wr_q, nack_q;
  logic [DATA_W-1:0]  rdata_cap_q;

  logic [NUM_REQ-1:0] pick_grant;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;
  logic               accept, finish;
  logic [1:0]         fin_status;
  logic [DATA_W-1:0]  rdata_now;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .valid     (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any_valid (pick_any)
  );

  always_ff @(posedge board_clk) begin
    if (reset) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    finish     = 1'b0;
    fin_status = ARB_STATUS_OK;
    case (state_q)
      ARB_IDLE: begin
        // Gating with reset keeps a requester from seeing an accept that the reset discards.
        if (codec_init_done && pick_any && !reset) begin
          accept  = 1'b1;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: state_d = ARB_WAIT_BUSY;
      ARB_WAIT_BUSY: begin
        if (controller_busy) begin
          state_d = ARB_WAIT_DONE;
        end else if (cnt_q == BUSY_LAST) begin
          finish     = 1'b1;
          fin_status = ARB_STATUS_TIMEOUT;
          state_d    = ARB_RESPOND;
        end
      end
      ARB_WAIT_DONE: begin
        if (!controller_busy) begin
          finish     = 1'b1;
          fin_status = (nack_q || missed_ack) ? ARB_STATUS_NACK : ARB_STATUS_OK;
          state_d    = ARB_RESPOND;
        end else if (cnt_q == DONE_LAST) begin
          finish     = 1'b1;
          fin_status = ARB_STATUS_TIMEOUT;
          state_d    = ARB_RESPOND;
        end
      end
      ARB_RESPOND: state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  // Read data arriving in the same cycle busy drops still belongs to this transaction.
  always_comb begin
    rdata_now = rdata_cap_q;
    if (state_q == ARB_WAIT_DONE && codec_data_out_valid && !wr_q) rdata_now = codec_data_out;
  end

  always_ff @(posedge board_clk) begin
    if (reset) begin
      cnt_q          <= '0;
      rr_ptr_q       <= '0;
      grant_idx_q    <= '0;
      wr_q           <= 1'b0;
      nack_q         <= 1'b0;
      rdata_cap_q    <= '0;
      codec_reg_addr <= '0;
      codec_data_in  <= '0;
      rsp_rdata      <= '0;
      rsp_status     <= ARB_STATUS_OK;
    end else begin
      if (state_d != state_q)
        cnt_q <= '0;
      else if (state_q == ARB_WAIT_BUSY || state_q == ARB_WAIT_DONE)
        cnt_q <= cnt_q + 1'b1;

      if (accept) begin
        grant_idx_q    <= pick_idx;
        wr_q           <= req_write[pick_idx];
        codec_reg_addr <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
        codec_data_in  <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
        nack_q         <= 1'b0;
        rdata_cap_q    <= '0;
        rsp_rdata      <= '0;
        rsp_status     <= ARB_STATUS_OK;
      end

      if (state_q == ARB_WAIT_DONE) begin
        if (missed_ack) nack_q <= 1'b1;
        if (codec_data_out_valid && !wr_q) rdata_cap_q <= codec_data_out;
      end

      if (finish) begin
        rsp_status <= fin_status;
        rsp_rdata  <= (fin_status == ARB_STATUS_OK && !wr_q) ? rdata_now : '0;
      end

      if (state_q == ARB_RESPOND) rr_ptr_q <= PTR_W'(rr_next(int'(grant_idx_q), NUM_REQ));
    end
  end

  always_comb begin
    req_ready = accept ? pick_grant : '0;
    rsp_valid = '0;
    if (state_q == ARB_RESPOND) rsp_valid[grant_idx_q] = 1'b1;
    codec_wr_en = (state_q == ARB_ISSUE) && wr_q;
    codec_rd_en = (state_q == ARB_ISSUE) && !wr_q;
  end

endmodule

// File: tb/tb_codec_i2c_arbiter.sv
// tb/tb_codec_i2c_arbiter.sv - self-checking bench for codec_i2c_arbiter
module tb_codec_i2c_arbiter;

  localparam int N    = 3;
  localparam int AW   = 8;
  localparam int DW   = 9;
  localparam int BUSY = 16;
  localparam int TO   = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req_valid = '0, req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0] req_ready, rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0] rsp_status;
  logic codec_init_done = 1'b0;
  logic codec_rd_en, codec_wr_en;
  logic [AW-1:0] codec_reg_addr;
  logic [DW-1:0] codec_data_in;
  logic [DW-1:0] codec_data_out = '0;
  logic codec_data_out_valid = 1'b0, controller_busy = 1'b0, missed_ack = 1'b0;

  codec_i2c_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BUSY_START_CYC(BUSY), .TIMEOUT_CYC(TO)) dut (
    .board_clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_status(rsp_status), .codec_init_done(codec_init_done),
    .codec_rd_en(codec_rd_en), .codec_wr_en(codec_wr_en), .codec_reg_addr(codec_reg_addr),
    .codec_data_in(codec_data_in), .codec_data_out(codec_data_out),
    .codec_data_out_valid(codec_data_out_valid), .controller_busy(controller_busy),
    .missed_ack(missed_ack)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  bit rst_q = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Transaction-level model: one transaction outstanding, rr pointer, held outputs.
  int ctl_mode = 0;
  logic [DW-1:0] ctl_data = '0;
  bit m_out = 0, m_wr = 0;
  int m_ptr = 0, m_g = 0, m_strobe = -1, m_rsp_cyc = -1;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0, m_erd = '0;
  logic [1:0] m_est = '0;
  bit s_act = 0;
  int s_on = 0, s_off = 0, s_nack = -1, s_dv = -1;
  logic [DW-1:0] s_data = '0;

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [N-1:0] e_ready, e_rsp;
    int g, d, len, nk, r;
    if (cyc >= 1) begin
      if (rst_q) begin
        m_out = 0; m_ptr = 0; m_addr = '0; m_wdata = '0; m_rdata = '0; s_act = 0;
      end
      e_ready = '0;
      g = rr_pick(req_valid, m_ptr);
      if (!m_out && codec_init_done && !reset && g >= 0) e_ready[g] = 1'b1;
      cmp("req_ready", req_ready, e_ready);
      cmp("codec_wr_en", codec_wr_en, m_out && cyc == m_strobe && m_wr);
      cmp("codec_rd_en", codec_rd_en, m_out && cyc == m_strobe && !m_wr);
      cmp("codec_reg_addr", codec_reg_addr, m_addr);
      cmp("codec_data_in", codec_data_in, m_wdata);
      e_rsp = '0;
      if (m_out && cyc == m_rsp_cyc) begin
        e_rsp[m_g] = 1'b1;
        m_rdata = m_erd;
      end
      cmp("rsp_valid", rsp_valid, e_rsp);
      cmp("rsp_rdata", rsp_rdata, m_rdata);
      if (|e_rsp) cmp("rsp_status", rsp_status, m_est);
      else if (rst_q) cmp("rsp_status_reset", rsp_status, 2'b00);
      if (|e_rsp) begin
        m_out = 0; m_ptr = (m_g + 1) % N; s_act = 0;
      end
      if (m_out && cyc == m_strobe) begin
        case (ctl_mode)
          1: begin d = 3; len = 40; nk = 0; end
          2: begin d = 2; len = 10; nk = 4; end
          3: begin d = 1000; len = 1; nk = 0; end
          4: begin d = 2; len = TO + 10; nk = 3; end
          default: begin
            d = $urandom_range(1, 20);
            r = $urandom % 16;
            len = (r == 0) ? TO + $urandom_range(1, 4) : (r == 1) ? TO : $urandom_range(1, 12);
            nk = (len >= 2 && $urandom % 4 == 0) ? $urandom_range(1, len - 1) : 0;
          end
        endcase
        s_on = cyc + d; s_off = cyc + d + len;
        s_nack = (nk != 0) ? cyc + d + nk : -1;
        s_dv = (!m_wr && len >= 2) ? cyc + d + len - 1 : -1;
        s_data = (ctl_mode == 0) ? DW'($urandom) : ctl_data;
        s_act = 1;
        if (d > BUSY) begin
          m_rsp_cyc = cyc + BUSY + 1; m_est = 2'b10; m_erd = '0;
        end else if (len > TO) begin
          m_rsp_cyc = cyc + d + TO + 1; m_est = 2'b10; m_erd = '0;
        end else begin
          m_rsp_cyc = cyc + d + len + 1;
          m_est = (nk != 0) ? 2'b01 : 2'b00;
          m_erd = (m_est == 2'b00 && s_dv >= 0) ? s_data : '0;
        end
      end
      if (|e_ready) begin
        m_out = 1; m_g = g; m_wr = req_write[g];
        m_addr = req_addr[g*AW +: AW]; m_wdata = req_wdata[g*DW +: DW];
        m_strobe = cyc + 1; m_rsp_cyc = -1; m_rdata = '0;
      end
    end
  end

  // Scripted CODEC controller
  always @(posedge clk) begin
    #1;
    controller_busy      = s_act && cyc >= s_on && cyc < s_off;
    missed_ack           = s_act && cyc == s_nack;
    codec_data_out_valid = s_act && cyc == s_dv;
    codec_data_out       = s_data;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1; req_write[i] = wr;
    req_addr[i*AW +: AW] = a; req_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int acc, output int stb, output bit stb_wr, output int rsp,
                        output logic [DW-1:0] rd, output logic [1:0] st);
    acc = -1; stb = -1; rsp = -1; stb_wr = 0; rd = '0; st = '0;
    set_req(i, wr, a, d);
    for (int k = 0; k < 300 && acc < 0; k++) begin
      @(negedge clk);
      if (req_ready[i]) acc = cyc;
    end
    tick();
    req_valid[i] = 1'b0;
    cmp("accept_seen", acc >= 0, 1);
    for (int k = 0; k < 300 && acc >= 0 && rsp < 0; k++) begin
      @(negedge clk);
      if (stb < 0 && (codec_wr_en || codec_rd_en)) begin stb = cyc; stb_wr = codec_wr_en; end
      if (rsp_valid[i]) begin rsp = cyc; rd = rsp_rdata; st = rsp_status; end
    end
    cmp("rsp_seen", rsp >= 0, 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300 && m_out; k++) begin @(negedge clk); #1; end
    cmp("idle_reached", m_out, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, tests %0d", n_tests);
    $fatal(1);
  end

  initial begin
    int acc, stb, rsp, bad, nacc, rsv;
    bit sw;
    logic [DW-1:0] rd;
    logic [1:0] st;
    int order[4];
    logic [N-1:0] r;

    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    cmp("rst_ready", req_ready, 0);
    cmp("rst_rsp_valid", rsp_valid, 0);
    cmp("rst_strobes", {codec_wr_en, codec_rd_en}, 0);

    // requests held while init not done must not be granted
    tick();
    ctl_mode = 1;
    set_req(0, 1'b1, 8'h07, 9'h012);
    bad = 0;
    repeat (8) begin @(negedge clk); if (|req_ready) bad++; end
    cmp("no_grant_before_init", bad, 0);
    tick();
    codec_init_done = 1'b1;
    rsv = cyc;
    do_req(0, 1'b1, 8'h07, 9'h012, acc, stb, sw, rsp, rd, st);
    cmp("grant_on_init", acc - rsv, 0);
    cmp("wr_strobe_delay", stb - acc, 1);
    cmp("wr_strobe_kind", sw, 1);
    cmp("wr_addr", codec_reg_addr, 8'h07);
    cmp("wr_data", codec_data_in, 9'h012);
    cmp("wr_status", st, 2'b00);
    cmp("wr_latency", rsp - acc, 45);
    cmp("wr_rdata", rd, 0);

    tick(); ctl_data = 9'h097;
    do_req(1, 1'b0, 8'h00, 9'h000, acc, stb, sw, rsp, rd, st);
    cmp("rd_strobe_kind", sw, 0);
    cmp("rd_rdata", rd, 9'h097);
    cmp("rd_status", st, 2'b00);

    tick(); ctl_mode = 2;
    do_req(0, 1'b0, 8'h11, 9'h000, acc, stb, sw, rsp, rd, st);
    cmp("nack_status", st, 2'b01);
    cmp("nack_rdata", rd, 0);

    tick(); ctl_mode = 3;
    do_req(1, 1'b1, 8'h22, 9'h1ff, acc, stb, sw, rsp, rd, st);
    cmp("nobusy_status", st, 2'b10);
    cmp("nobusy_latency", rsp - acc, 18);

    tick(); ctl_mode = 4;
    do_req(2, 1'b0, 8'h33, 9'h000, acc, stb, sw, rsp, rd, st);
    cmp("longbusy_status", st, 2'b10);
    cmp("longbusy_latency", rsp - acc, 68);

    // reset while the controller is busy
    tick(); ctl_mode = 1;
    set_req(0, 1'b1, 8'h5a, 9'h155);
    acc = -1;
    for (int k = 0; k < 50 && acc < 0; k++) begin @(negedge clk); if (req_ready[0]) acc = cyc; end
    cmp("rst_txn_accept", acc >= 0, 1);
    tick(); req_valid[0] = 1'b0;
    repeat (10) @(negedge clk);
    cmp("rst_txn_busy", controller_busy, 1);
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    @(negedge clk);
    cmp("midrst_ready", req_ready, 0);
    cmp("midrst_rsp_valid", rsp_valid, 0);
    cmp("midrst_strobes", {codec_wr_en, codec_rd_en}, 0);
    cmp("midrst_addr", codec_reg_addr, 0);
    cmp("midrst_data", codec_data_in, 0);
    cmp("midrst_rdata", rsp_rdata, 0);
    cmp("midrst_status", rsp_status, 0);
    bad = 0;
    repeat (60) begin @(negedge clk); if (|rsp_valid) bad++; end
    cmp("no_rsp_after_reset", bad, 0);
    tick(); ctl_data = 9'h0a5;
    do_req(1, 1'b0, 8'h00, 9'h000, acc, stb, sw, rsp, rd, st);
    cmp("post_rst_rdata", rd, 9'h0a5);
    cmp("post_rst_status", st, 2'b00);

    // fairness with two requesters held continuously
    tick(); ctl_mode = 2;
    set_req(0, 1'b1, 8'h01, 9'h001);
    set_req(1, 1'b1, 8'h02, 9'h002);
    nacc = 0;
    for (int k = 0; k < 1500 && nacc < 4; k++) begin
      @(negedge clk);
      if (req_ready[0]) begin order[nacc] = 0; nacc++; end
      else if (req_ready[1]) begin order[nacc] = 1; nacc++; end
    end
    tick(); req_valid = '0;
    cmp("fair_count", nacc, 4);
    for (int k = 0; k < 4; k++) cmp("fair_order", (k < nacc) ? order[k] : -1, k % 2);
    wait_idle();

    // randomized traffic
    ctl_mode = 0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk); r = req_ready;
      tick();
      for (int i = 0; i < N; i++) begin
        if (r[i]) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom % 4 == 0)
          set_req(i, 1'($urandom), AW'($urandom), DW'($urandom));
        else if (req_valid[i] && $urandom % 64 == 0) req_valid[i] = 1'b0;
      end
      if (codec_init_done && $urandom % 200 == 0) codec_init_done = 1'b0;
      else if (!codec_init_done && $urandom % 20 == 0) codec_init_done = 1'b1;
    end
    @(negedge clk);
    tick(); req_valid = '0; codec_init_done = 1'b1;
    wait_idle();
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
